// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO port: register byte offsets and the
// interrupt type/polarity bit encodings.
package gpio_pkg;

  localparam int unsigned APB_DW = 32;

  localparam logic [11:0] OFF_DATAIN    = 12'h000;
  localparam logic [11:0] OFF_DATAOUT   = 12'h004;
  localparam logic [11:0] OFF_OUTEN     = 12'h008;
  localparam logic [11:0] OFF_INTEN     = 12'h00C;
  localparam logic [11:0] OFF_INTTYPE   = 12'h010;
  localparam logic [11:0] OFF_INTPOL    = 12'h014;
  localparam logic [11:0] OFF_INTSTATUS = 12'h018;

  localparam logic INTTYPE_EDGE  = 1'b1;
  localparam logic INTTYPE_LEVEL = 1'b0;
  localparam logic INTPOL_HIGH   = 1'b1;
  localparam logic INTPOL_LOW    = 1'b0;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer bringing the asynchronous pad inputs into the PCLK domain.
module gpio_sync #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/apb_gpio_port.sv
// APB3 GPIO port: output data/enable registers, synchronized input sampling and
// per-bit edge/level interrupts with write-1-to-clear status.
module apb_gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned PORTWIDTH = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [11:2]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [PORTWIDTH-1:0] PORTIN,
  output logic [PORTWIDTH-1:0] PORTOUT,
  output logic [PORTWIDTH-1:0] PORTEN,
  output logic [PORTWIDTH-1:0] GPIOINT,
  output logic                 COMBINT
);

  logic [PORTWIDTH-1:0] dataout_q, dataout_d;
  logic [PORTWIDTH-1:0] outen_q, outen_d;
  logic [PORTWIDTH-1:0] inten_q, inten_d;
  logic [PORTWIDTH-1:0] inttype_q, inttype_d;
  logic [PORTWIDTH-1:0] intpol_q, intpol_d;
  logic [PORTWIDTH-1:0] intstat_q, intstat_d;
  logic [PORTWIDTH-1:0] prev_q;
  logic [PORTWIDTH-1:0] sync_in;
  logic [PORTWIDTH-1:0] set_vec;
  logic [PORTWIDTH-1:0] w1c_vec;
  logic [PORTWIDTH-1:0] wdata;
  logic [11:0]          byte_addr;
  logic                 wr_en;
  logic                 unused_wdata_bits;

  gpio_sync #(.WIDTH(PORTWIDTH)) u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .d_i     (PORTIN),
    .q_o     (sync_in)
  );

  assign byte_addr         = {PADDR, 2'b00};
  assign wr_en             = PSEL & PENABLE & PWRITE;
  assign wdata             = PWDATA[PORTWIDTH-1:0];
  assign unused_wdata_bits = ^PWDATA;

  // Edge detection compares the synchronized value with its one-cycle-old copy,
  // so a change of INTTYPE/INTPOL alone can never fabricate an edge.
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < int'(PORTWIDTH); i++) begin
      if (inten_q[i]) begin
        if (inttype_q[i] == INTTYPE_EDGE) begin
          set_vec[i] = (intpol_q[i] == INTPOL_HIGH) ? (sync_in[i] & ~prev_q[i])
                                                    : (~sync_in[i] & prev_q[i]);
        end else begin
          set_vec[i] = (intpol_q[i] == INTPOL_HIGH) ? sync_in[i] : ~sync_in[i];
        end
      end
    end
  end

  always_comb begin
    dataout_d = dataout_q;
    outen_d   = outen_q;
    inten_d   = inten_q;
    inttype_d = inttype_q;
    intpol_d  = intpol_q;
    w1c_vec   = '0;
    if (wr_en) begin
      case (byte_addr)
        OFF_DATAOUT:   dataout_d = wdata;
        OFF_OUTEN:     outen_d   = wdata;
        OFF_INTEN:     inten_d   = wdata;
        OFF_INTTYPE:   inttype_d = wdata;
        OFF_INTPOL:    intpol_d  = wdata;
        OFF_INTSTATUS: w1c_vec   = wdata;
        default:       ;
      endcase
    end
    // A new set condition beats a simultaneous clear of the same bit.
    intstat_d = (intstat_q & ~w1c_vec) | set_vec;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dataout_q <= '0;
      outen_q   <= '0;
      inten_q   <= '0;
      inttype_q <= '0;
      intpol_q  <= '0;
      intstat_q <= '0;
      prev_q    <= '0;
    end else begin
      dataout_q <= dataout_d;
      outen_q   <= outen_d;
      inten_q   <= inten_d;
      inttype_q <= inttype_d;
      intpol_q  <= intpol_d;
      intstat_q <= intstat_d;
      prev_q    <= sync_in;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (byte_addr)
        OFF_DATAIN:    PRDATA[PORTWIDTH-1:0] = sync_in;
        OFF_DATAOUT:   PRDATA[PORTWIDTH-1:0] = dataout_q;
        OFF_OUTEN:     PRDATA[PORTWIDTH-1:0] = outen_q;
        OFF_INTEN:     PRDATA[PORTWIDTH-1:0] = inten_q;
        OFF_INTTYPE:   PRDATA[PORTWIDTH-1:0] = inttype_q;
        OFF_INTPOL:    PRDATA[PORTWIDTH-1:0] = intpol_q;
        OFF_INTSTATUS: PRDATA[PORTWIDTH-1:0] = intstat_q;
        default:       PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign PORTOUT = dataout_q;
  assign PORTEN  = outen_q;
  assign GPIOINT = intstat_q & inten_q;
  assign COMBINT = |GPIOINT;

endmodule

// File: tb/tb_apb_gpio_port.sv
// Directed bench for apb_gpio_port: reset values, output registers, input
// synchronizer latency, edge/level interrupts, W1C behaviour and unmapped offsets.
module tb_apb_gpio_port;

  localparam int unsigned PW = 16;

  logic          PCLK;
  logic          PRESETn;
  logic          PSEL, PENABLE, PWRITE;
  logic [11:2]   PADDR;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [PW-1:0] PORTIN, PORTOUT, PORTEN, GPIOINT;
  logic          COMBINT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  apb_gpio_port #(.PORTWIDTH(PW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .PORTIN  (PORTIN),
    .PORTOUT (PORTOUT),
    .PORTEN  (PORTEN),
    .GPIOINT (GPIOINT),
    .COMBINT (COMBINT)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr[11:2]; PWDATA = data;
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr[11:2];
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    check("pready", {31'b0, PREADY}, 32'h1);
    check("pslverr", {31'b0, PSLVERR}, 32'h0);
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // zero-edge access-phase read, used for cycle-exact latency checks
  task automatic peek(input logic [11:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = addr[11:2];
    #1;
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
    end
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PORTIN = '0;
    idle(3);
    check("rst_portout", {16'b0, PORTOUT}, 32'h0);
    check("rst_porten", {16'b0, PORTEN}, 32'h0);
    check("rst_combint", {31'b0, COMBINT}, 32'h0);
    PRESETn = 1'b1;
    idle(1);
    for (int a = 0; a <= 6; a++) begin
      apb_read(12'(a * 4), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'h0);
    end
    peek(12'h000, rd);
    check("psel0_prdata", PRDATA, 32'h0);

    // output registers
    apb_write(12'h004, 32'h0000A5A5);
    check("portout", {16'b0, PORTOUT}, 32'h0000A5A5);
    apb_write(12'h008, 32'h000000FF);
    check("porten", {16'b0, PORTEN}, 32'h000000FF);
    apb_read(12'h004, rd); check("rd_dataout", rd, 32'h0000A5A5);
    apb_read(12'h008, rd); check("rd_outen", rd, 32'h000000FF);
    apb_write(12'h004, 32'h12345A5A);
    apb_read(12'h004, rd); check("rd_dataout_trunc", rd, 32'h00005A5A);

    // input synchronizer latency
    PORTIN = 16'h1234;
    peek(12'h000, rd); check("datain_e0", rd, 32'h0);
    idle(1);
    peek(12'h000, rd); check("datain_e1", rd, 32'h0);
    idle(1);
    peek(12'h000, rd); check("datain_e2", rd, 32'h00001234);
    apb_write(12'h000, 32'hFFFFFFFF);
    apb_read(12'h000, rd); check("datain_ro", rd, 32'h00001234);

    // edge interrupt on bit 0, rising
    PORTIN = 16'h0000;
    idle(3);
    apb_write(12'h010, 32'h1);
    apb_write(12'h014, 32'h1);
    apb_write(12'h00C, 32'h1);
    apb_read(12'h018, rd); check("edge_pre", rd, 32'h0);
    PORTIN = 16'h0001;
    idle(1);
    peek(12'h018, rd); check("edge_e1", rd, 32'h0);
    idle(1);
    peek(12'h018, rd); check("edge_e2", rd, 32'h0);
    idle(1);
    peek(12'h018, rd); check("edge_e3", rd, 32'h1);
    check("edge_gpioint", {16'b0, GPIOINT}, 32'h1);
    check("edge_combint", {31'b0, COMBINT}, 32'h1);
    apb_write(12'h018, 32'h1);
    apb_read(12'h018, rd); check("edge_w1c", rd, 32'h0);
    check("edge_combint_clr", {31'b0, COMBINT}, 32'h0);
    PORTIN = 16'h0000;
    idle(4);
    apb_read(12'h018, rd); check("edge_fall_noset", rd, 32'h0);

    // level interrupt on bit 1, low
    apb_write(12'h00C, 32'h0);
    apb_write(12'h010, 32'h0);
    apb_write(12'h014, 32'h0);
    apb_write(12'h00C, 32'h2);
    idle(1);
    peek(12'h018, rd); check("lvl_set", rd, 32'h2);
    check("lvl_gpioint", {16'b0, GPIOINT}, 32'h2);
    apb_write(12'h018, 32'h2);
    apb_read(12'h018, rd); check("lvl_setwins", rd, 32'h2);
    apb_write(12'h00C, 32'h0);
    apb_read(12'h018, rd); check("lvl_inten_off_keep", rd, 32'h2);
    check("lvl_inten_off_gpioint", {16'b0, GPIOINT}, 32'h0);
    check("lvl_inten_off_combint", {31'b0, COMBINT}, 32'h0);
    apb_write(12'h00C, 32'h2);
    PORTIN = 16'h0002;
    idle(3);
    apb_write(12'h018, 32'h2);
    apb_read(12'h018, rd); check("lvl_w1c", rd, 32'h0);

    // unmapped offset
    apb_write(12'h040, 32'hFFFFFFFF);
    apb_read(12'h040, rd); check("unmapped", rd, 32'h0);
    apb_read(12'h004, rd); check("unmapped_noalias", rd, 32'h00005A5A);

    // reset in the middle of a write
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 10'h001; PWDATA = 32'h0000FFFF;
    @(posedge PCLK);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    check("midrst_portout", {16'b0, PORTOUT}, 32'h0);
    check("midrst_porten", {16'b0, PORTEN}, 32'h0);
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESETn = 1'b1;
    idle(1);
    apb_read(12'h004, rd); check("midrst_dataout", rd, 32'h0);
    apb_read(12'h00C, rd); check("midrst_inten", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
